divider_bf16: RTL

- Multi-cycle bfloat16 divider: output_div = input_a / input_b. It is the inverse-operation companion to the team's bf16 multiplier in the SyNCiN co-processor datapath.
- Uses the same STB/BUSY input and output handshake as the multiplier, so the two blocks are drop-in interchangeable behind the co-processor dispatcher.
- Mantissa quotient is computed by restoring division, one bit per cycle.
- Rounding is round-to-nearest-even; denormals are supported on input and output.

---
 rtl/divider_bf16.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/divider_bf16.sv
// Multi-cycle bfloat16 divider: output_div = input_a / input_b.
// STB/BUSY handshake on both sides; the mantissa quotient comes from
// restoring division, one bit per cycle, followed by round-to-nearest-even.
module divider_bf16 #(
    parameter int DIV_ITERS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] input_a,
    input  logic [15:0] input_b,
    input  logic        div_input_STB,
    output logic        div_BUSY,
    output logic [15:0] output_div,
    output logic        div_output_STB,
    input  logic        output_module_BUSY
);

    typedef enum logic [3:0] {
        GET_AB, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_0, DIV_1,
        DIV_2, NORM_1, NORM_2, ROUND, PACK, PUT_Z
    } state_t;

    localparam logic signed [9:0] E_DEN = -10'sd127;  // zero/denormal exponent field
    localparam logic signed [9:0] E_MIN = -10'sd126;
    localparam logic signed [9:0] E_MAX = 10'sd127;
    localparam logic signed [9:0] E_INF = 10'sd128;   // inf/NaN exponent field

    state_t state, state_next;

    logic [15:0]       a, b, z;
    logic [7:0]        a_m, b_m, z_m;
    logic signed [9:0] a_e, b_e, z_e;
    logic              a_s, b_s, z_s;
    logic [8:0]        rem;
    logic [11:0]       quo;
    logic [3:0]        count;
    logic              guard, round_bit, sticky;

    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              is_special;
    logic [15:0]       special_z;
    logic              div_q;
    logic [7:0]        rem_diff;
    logic [7:0]        exp_field;

    assign a_nan  = (a_e == E_INF) && (a_m != 8'd0);
    assign b_nan  = (b_e == E_INF) && (b_m != 8'd0);
    assign a_inf  = (a_e == E_INF) && (a_m == 8'd0);
    assign b_inf  = (b_e == E_INF) && (b_m == 8'd0);
    assign a_zero = (a_e == E_DEN) && (a_m == 8'd0);
    assign b_zero = (b_e == E_DEN) && (b_m == 8'd0);
    assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    // Restoring step: remainder stays below 2*b_m, so the difference fits in 8 bits.
    assign div_q    = (rem >= {1'b0, b_m});
    assign rem_diff = div_q ? 8'(rem - {1'b0, b_m}) : rem[7:0];

    // Special-case result, checked in priority order.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        special_z = 16'hFFC0;
        if (a_nan || b_nan)             special_z = 16'hFFC0;
        else if (a_inf && b_inf)        special_z = 16'hFFC0;
        else if (a_zero && b_zero)      special_z = 16'hFFC0;
        else if (a_inf)                 special_z = {a_s ^ b_s, 8'hFF, 7'h00};
        else if (b_inf)                 special_z = {a_s ^ b_s, 15'h0000};
        else if (b_zero)                special_z = {a_s ^ b_s, 8'hFF, 7'h00};
        else if (a_zero)                special_z = {a_s ^ b_s, 15'h0000};
    end

    // Biased exponent field for packing; zero when the result is denormal.
    always_comb begin
        exp_field = 8'(z_e + 10'sd127);
        if (z_e == E_MIN && !z_m[7]) exp_field = 8'h00;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= GET_AB;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            GET_AB:  if (div_input_STB && !div_BUSY) state_next = UNPACK;
            UNPACK:  state_next = SPECIAL;
            SPECIAL: state_next = is_special ? PUT_Z : NORM_A;
            NORM_A:  if (a_m[7]) state_next = NORM_B;
            NORM_B:  if (b_m[7]) state_next = DIV_0;
            DIV_0:   state_next = DIV_1;
            DIV_1:   if (count == 4'(DIV_ITERS - 1)) state_next = DIV_2;
            DIV_2:   state_next = NORM_1;
            NORM_1:  if (z_m[7]) state_next = NORM_2;
            NORM_2:  if (z_e >= E_MIN) state_next = ROUND;
            ROUND:   state_next = PACK;
            PACK:    state_next = PUT_Z;
            PUT_Z:   if (div_output_STB && !output_module_BUSY) state_next = GET_AB;
            default: state_next = GET_AB;
        endcase
    end

    // Datapath and handshake registers, advanced according to the current state.
    always_ff @(posedge clk) begin
        // NOTE: only handshake/output registers are reset; datapath registers are always written before use.
        if (rst) begin
            div_BUSY       <= 1'b0;
            div_output_STB <= 1'b0;
            output_div     <= 16'h0000;
        end else begin
            case (state)
                GET_AB: begin
                    if (div_input_STB && !div_BUSY) begin
                        a        <= input_a;
                        b        <= input_b;
                        div_BUSY <= 1'b1;
                    end else begin
                        div_BUSY <= 1'b0;
                    end
                end
                UNPACK: begin
                    a_m <= {1'b0, a[6:0]};
                    b_m <= {1'b0, b[6:0]};
                    a_e <= $signed({2'b00, a[14:7]}) - 10'sd127;
                    b_e <= $signed({2'b00, b[14:7]}) - 10'sd127;
                    a_s <= a[15];
                    b_s <= b[15];
                end
                SPECIAL: begin
                    if (is_special) begin
                        z <= special_z;
                    end else begin
                        if (a_e == E_DEN) a_e <= E_MIN;
                        else              a_m[7] <= 1'b1;
                        if (b_e == E_DEN) b_e <= E_MIN;
                        else              b_m[7] <= 1'b1;
                    end
                end
                NORM_A: begin
                    if (!a_m[7]) begin
                        a_m <= {a_m[6:0], 1'b0};
                        a_e <= a_e - 10'sd1;
                    end
                end
                NORM_B: begin
                    if (!b_m[7]) begin
                        b_m <= {b_m[6:0], 1'b0};
                        b_e <= b_e - 10'sd1;
                    end
                end
                DIV_0: begin
                    z_s   <= a_s ^ b_s;
                    z_e   <= a_e - b_e;
                    rem   <= {1'b0, a_m};
                    quo   <= 12'd0;
                    count <= 4'd0;
                end
                DIV_1: begin
                    rem   <= {rem_diff, 1'b0};
                    quo   <= {quo[10:0], div_q};
                    count <= count + 4'd1;
                end
                DIV_2: begin
                    z_m       <= quo[11:4];
                    guard     <= quo[3];
                    round_bit <= quo[2];
                    sticky    <= (|quo[1:0]) | (rem != 9'd0);
                end
                NORM_1: begin
                    if (!z_m[7]) begin
                        z_m       <= {z_m[6:0], guard};
                        guard     <= round_bit;
                        round_bit <= 1'b0;
                        z_e       <= z_e - 10'sd1;
                    end
                end
                NORM_2: begin
                    if (z_e < E_MIN) begin
                        z_e       <= z_e + 10'sd1;
                        z_m       <= {1'b0, z_m[7:1]};
                        guard     <= z_m[0];
                        round_bit <= guard;
                        sticky    <= sticky | round_bit;
                    end
                end
                ROUND: begin
                    if (guard && (round_bit || sticky || z_m[0])) begin
                        z_m <= z_m + 8'd1;
                        if (z_m == 8'hFF) z_e <= z_e + 10'sd1;
                    end
                end
                PACK: begin
                    if (z_e > E_MAX) z <= {z_s, 8'hFF, 7'h00};
                    else             z <= {z_s, exp_field, z_m[6:0]};
                end
                PUT_Z: begin
                    if (!div_output_STB) begin
                        output_div     <= z;
                        div_output_STB <= 1'b1;
                    end else if (!output_module_BUSY) begin
                        div_output_STB <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
